matrix_c_drain: RTL and testbench
=================================

MATRIX_C_DRAIN -- requirements
Module: matrix_c_drain

Interface
REQ-001 SHALL have parameter DATA_W, default 19, giving the signed width of one result element of C.
REQ-002 SHALL have port clk, input, 1 bit: the clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: begin draining one 8x8 result matrix; sampled only in IDLE.
REQ-005 SHALL have port mem_rd, output, 1 bit: read strobe to the result RAM.
REQ-006 SHALL have port mem_addr, output, 6 bits: read address into the result RAM.
REQ-007 SHALL have port mem_rdata, input, DATA_W bits, signed: read data, valid the cycle after mem_rd.
REQ-008 SHALL have port out_data, output, DATA_W bits, signed: streamed element.
REQ-009 SHALL have ports out_row and out_col, output, 3 bits each: matrix indices of out_data.
REQ-010 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: stream handshake.
REQ-011 SHALL have port out_last, output, 1 bit: high with element (7,7).
REQ-012 SHALL have port busy, output, 1 bit, and port done, output, 1 bit: done is a one-cycle completion pulse.
REQ-013 SHALL have port checksum, output, DATA_W+6 bits, signed, present only under DRAIN_CHECKSUM_EN.

Function
REQ-014 SHALL use the states IDLE, RUN and DONE: IDLE->RUN on start, RUN->DONE on the out_last handshake, DONE->IDLE unconditionally after one cycle.
REQ-015 SHALL emit elements in row-major order (r=0..7, c=0..7) and SHALL read element (r,c) from mem_addr = c*8 + r, the column-major storage layout of the array.
REQ-016 SHALL complete a handshake, and advance the stream, only on an edge where out_valid && out_ready.
REQ-017 SHALL hold out_data, out_row, out_col and out_last stable while out_valid=1 and out_ready=0.
REQ-018 SHALL buffer returned read data in a 2-entry FIFO; out_valid SHALL equal FIFO non-empty.
REQ-019 SHALL issue a read only when 2 - fifo_count - reads_in_flight + (pop this cycle) >= 1, so that no returned data is ever dropped.
REQ-020 SHALL, with out_ready held at 1, drive mem_rd in the cycle after the start edge and out_valid from the second edge after start onward, sustaining one element per cycle.
REQ-021 SHALL issue exactly 64 reads per run and no reads outside RUN.
REQ-022 SHALL assert busy in RUN only; start SHALL be ignored in RUN and DONE.
REQ-023 SHALL assert done for exactly the DONE cycle.

Reset
REQ-024 SHALL, while rst=1 including mid-run, force IDLE, empty the FIFO and clear counters; every output SHALL be 0, including checksum.
REQ-025 SHALL discard any mem_rdata returning in the cycle after reset is released.

Configuration
REQ-026 SHALL, with DRAIN_CHECKSUM_EN defined, clear checksum when start is accepted, add each handshaked out_data sign-extended to DATA_W+6 bits, and hold the final value from the DONE cycle until the next accepted start.
REQ-027 SHALL, without DRAIN_CHECKSUM_EN, omit the checksum port and its accumulator; all other behaviour SHALL be identical.

Verification
REQ-028 SHALL cover: RAM[a]=a, out_ready=1, start pulse -> out_data sequence 0,8,16,...,56,1,9,...,63; out_last only on 63; 64 consecutive valid cycles; done one cycle after the last handshake.
REQ-029 SHALL cover: out_ready toggling 1,0,1,0 and random -> the same 64-value sequence with no drop or duplicate, outputs stable across stalls, and FIFO never overflowing.
REQ-030 SHALL cover: all RAM entries = -262144 with DRAIN_CHECKSUM_EN -> checksum = -16777216 at done; all entries = 262143 -> checksum = 16777152.
REQ-031 SHALL cover: rst asserted after 10 handshakes -> all outputs 0 immediately; the next start restarts at (0,0) with mem_addr=0.
REQ-032 SHALL cover: start pulsed during RUN -> ignored; start held high -> back-to-back runs with one DONE cycle between them and busy low in that cycle.

Source files
------------

// File: rtl/matrix_c_drain.sv
// Streams an 8x8 column-major result matrix out in row-major order.
// Define DRAIN_CHECKSUM_EN to add a running signed checksum output.
module matrix_c_drain #(
  parameter int DATA_W = 19
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     mem_rd,
  output logic [5:0]               mem_addr,
  input  logic signed [DATA_W-1:0] mem_rdata,
  output logic signed [DATA_W-1:0] out_data,
  output logic [2:0]               out_row,
  output logic [2:0]               out_col,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
`ifdef DRAIN_CHECKSUM_EN
  output logic                     done,
  output logic signed [DATA_W+5:0] checksum
`else
  output logic                     done
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;

  logic [6:0] rd_cnt;
  logic [5:0] out_idx;
  logic       rd_q;

  logic signed [DATA_W-1:0] fifo [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;

  logic       push;
  logic       pop;
  logic [2:0] occ;
  logic       rd_ok;
  logic       head_last;

  assign push      = rd_q;
  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign head_last = (out_idx == 6'd63);

  // Slots already claimed: buffered entries plus the read whose data
  // lands next edge. A pop this cycle frees one slot in time.
  assign occ   = {1'b0, count} + {2'b00, rd_q};
  assign rd_ok = (occ < 3'd2) || ((occ == 3'd2) && pop);

  assign mem_rd   = (state == RUN) && !rd_cnt[6] && rd_ok;
  assign mem_addr = mem_rd ? {rd_cnt[2:0], rd_cnt[5:3]} : 6'd0;

  assign out_data = out_valid ? fifo[rd_ptr] : '0;
  assign out_row  = out_valid ? out_idx[5:3] : 3'd0;
  assign out_col  = out_valid ? out_idx[2:0] : 3'd0;
  assign out_last = out_valid && head_last;

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      out_idx <= '0;
      rd_q    <= 1'b0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= '0;
      fifo[0] <= '0;
      fifo[1] <= '0;
    end else begin
      rd_q  <= mem_rd;
      count <= count + {1'b0, push} - {1'b0, pop};
      if (push) begin
        fifo[wr_ptr] <= mem_rdata;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        out_idx <= out_idx + 6'd1;
      end
      if (mem_rd) begin
        rd_cnt <= rd_cnt + 7'd1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            rd_cnt  <= '0;
            out_idx <= '0;
          end
        end
        RUN: begin
          if (pop && head_last) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef DRAIN_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if ((state == IDLE) && start) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + (DATA_W + 6)'(out_data);
    end
  end
`endif

endmodule

// File: tb/tb_matrix_c_drain.sv
// Randomized bench for matrix_c_drain against a row-major stream model.
// Checksum checks compile in only when DRAIN_CHECKSUM_EN is defined.
module tb_matrix_c_drain;
  localparam int W = 19;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic out_ready = 1'b0;
  logic mem_rd;
  logic [5:0] mem_addr;
  logic signed [W-1:0] mem_rdata;
  logic signed [W-1:0] out_data;
  logic [2:0] out_row;
  logic [2:0] out_col;
  logic out_valid;
  logic out_last;
  logic busy;
  logic done;
`ifdef DRAIN_CHECKSUM_EN
  logic signed [W+5:0] checksum;
`endif

  matrix_c_drain #(.DATA_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
    .out_data(out_data),
    .out_row(out_row),
    .out_col(out_col),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .busy(busy),
`ifdef DRAIN_CHECKSUM_EN
    .done(done),
    .checksum(checksum)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  logic signed [W-1:0] ram [64];

  always @(posedge clk) begin
    mem_rdata <= mem_rd ? ram[mem_addr] : W'($urandom);
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Reference model state: k-th handshake must carry element
  // (k/8, k%8), read from RAM at column-major address.
  int hs_k = 0;
  int rd_k = 0;
  int cyc = 0;
  int first_v = 0;
  int vcyc = 0;
  int ready_mode = 0;
  longint exp_sum = 0;
  bit last_prev = 0;
  bit pv = 0;
  bit pr = 0;
  logic [31:0] prev_out;
  logic signed [W-1:0] seq [64];

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_outputs",
          {mem_rd, mem_addr, out_data, out_row, out_col,
           out_valid, out_last, busy, done} != 0, 0);
`ifdef DRAIN_CHECKSUM_EN
      chk("rst_checksum", checksum, 0);
`endif
      hs_k = 0;
      rd_k = 0;
      vcyc = 0;
      exp_sum = 0;
      last_prev = 0;
      pv = 0;
    end else begin
      chk("done_after_last", done, last_prev);
      if (mem_rd) begin
        chk("rd_in_busy", busy, 1);
        chk("mem_addr", mem_addr, (rd_k % 8) * 8 + rd_k / 8);
        rd_k++;
      end
      if (pv && !pr) begin
        chk("stall_stable",
            {4'b0, out_valid, out_data, out_row, out_col, out_last}, prev_out);
      end
      if (out_valid) begin
        if (vcyc == 0) first_v = cyc;
        vcyc++;
        chk("out_row", out_row, hs_k / 8);
        chk("out_col", out_col, hs_k % 8);
        chk("out_data", out_data, ram[(hs_k % 8) * 8 + hs_k / 8]);
        chk("out_last", out_last, hs_k == 63);
      end else begin
        chk("last_idle", out_last, 0);
      end
      pv = out_valid;
      pr = out_ready;
      prev_out = {4'b0, out_valid, out_data, out_row, out_col, out_last};
      last_prev = out_valid && out_ready && out_last;
      if (out_valid && out_ready) begin
        seq[hs_k % 64] = out_data;
        exp_sum += out_data;
        hs_k++;
      end
      chk("fifo_bound", (rd_k - hs_k) <= 2, 1);
      if (done) begin
        chk("busy_in_done", busy, 0);
        chk("reads_per_run", rd_k, 64);
        chk("hs_per_run", hs_k, 64);
        if (ready_mode == 0) chk("valid_span", cyc - 1 - first_v, 63);
`ifdef DRAIN_CHECKSUM_EN
        chk("checksum_model", checksum, exp_sum);
`endif
        hs_k = 0;
        rd_k = 0;
        vcyc = 0;
        exp_sum = 0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ~out_ready;
        default: out_ready = 1'($urandom);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done(input int maxc);
    for (int i = 0; i < maxc && !done; i++) tick();
    chk("done_seen", done, 1);
  endtask

  task automatic run_one(input int maxc);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(maxc);
    tick();
  endtask

  initial begin
    for (int a = 0; a < 64; a++) ram[a] = W'(a);
    ready_mode = 0;
    repeat (3) tick();
    chk("rst_valid", out_valid, 0);
    rst = 1'b0;
    tick();

    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rd_after_start", mem_rd, 1);
    chk("first_addr", mem_addr, 0);
    chk("busy_run", busy, 1);
    chk("valid_e1", out_valid, 0);
    tick();
    chk("valid_e2_low", out_valid, 0);
    tick();
    chk("valid_e3", out_valid, 1);
    chk("first_data", out_data, 0);
    wait_done(200);
    chk("seq1", seq[1], 8);
    chk("seq7", seq[7], 56);
    chk("seq8", seq[8], 1);
    chk("seq63", seq[63], 63);
    tick();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    ready_mode = 1;
    run_one(400);
    ready_mode = 2;
    run_one(600);

    for (int a = 0; a < 64; a++) ram[a] = -19'sd262144;
    run_one(600);
`ifdef DRAIN_CHECKSUM_EN
    chk("sum_min", checksum, -25'sd16777216);
    repeat (3) tick();
    chk("sum_hold", checksum, -25'sd16777216);
`endif
    for (int a = 0; a < 64; a++) ram[a] = 19'sd262143;
    run_one(600);
`ifdef DRAIN_CHECKSUM_EN
    chk("sum_max", checksum, 25'sd16777152);
`endif

    for (int a = 0; a < 64; a++) ram[a] = W'($urandom);
    run_one(600);
    ready_mode = 0;
    run_one(200);

    for (int a = 0; a < 64; a++) ram[a] = W'(a);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100 && hs_k < 10; i++) tick();
    chk("hs_ten", hs_k, 10);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_rd", mem_rd, 0);
    chk("rst_mid_data", out_data, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_rd", mem_rd, 1);
    chk("restart_addr", mem_addr, 0);
    wait_done(200);
    chk("restart_seq0", seq[0], 0);
    chk("restart_seq1", seq[1], 8);
    tick();

    ready_mode = 2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(600);
    repeat (3) tick();
    chk("ignored_start", busy, 0);

    ready_mode = 0;
    start = 1'b1;
    wait_done(200);
    chk("held_done_busy", busy, 0);
    tick();
    tick();
    chk("held_rerun", busy, 1);
    wait_done(200);
    start = 1'b0;
    repeat (4) tick();
    chk("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
